lsu: RTL and testbench

Load/store unit sitting directly downstream of the ALU control stage in the execute path. Takes the ALU result as the effective address plus the rs2 value and funct3 for loads (opcode 0000011) and stores (opcode 0100011). Runs one word-aligned transaction on the data-memory bus with byte strobes, then sign/zero-extends and lane-shifts load data. Returns a writeback response to the register-file stage.

---
 rtl/lsu.sv | 287 ++++++++++++++++++++++++++++
 tb/tb_lsu.sv | 446 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit for the execute path
//
// Purpose:
//   Accepts one load or store at a time from the execute stage. It decodes
//   funct3 into an access size and a signedness, checks for illegal encodings,
//   and runs a single word-aligned transaction on the data-memory bus with
//   byte strobes. Load data is lane-shifted and then sign- or zero-extended.
//   A writeback response is presented to the register-file stage.
//
// Configuration macro:
//   LSU_MISALIGN_TRAP_EN
//     defined   : misaligned H/W accesses take the fault path (no bus cycle).
//     undefined : alignment is not checked. The address is forced aligned
//                 for the access size, and only an illegal funct3 faults.
//
// Ports:
//   clk, rst_n        clock (rising edge) and asynchronous active-low reset
//   req_valid/ready   request handshake from execute; ready only while idle
//   req_store         1 = store, 0 = load
//   req_funct3        000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr          effective byte address
//   req_wdata         store data (rs2)
//   req_rd            load destination register
//   mem_req           bus request, held until mem_ack
//   mem_we            bus write enable
//   mem_addr          word address (low two bits zero)
//   mem_wstrb         byte-lane strobes
//   mem_wdata         store data replicated across lanes
//   mem_ack           bus completion; read data valid in the same cycle
//   mem_rdata         bus read word
//   resp_valid/ready  writeback handshake
//   resp_we           register write requested (load, no fault, rd != 0)
//   resp_rd           destination register
//   resp_data         extended load data, 0 for stores and faults
//   resp_fault        misaligned access or illegal funct3
// ---------------------------------------------------------------------------
module lsu #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_store,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic              resp_we,
    output logic [4:0]        resp_rd,
    output logic [31:0]       resp_data,
    output logic              resp_fault
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    state_t state;
    state_t state_next;

    // Decode of the request currently offered on the req_* inputs.
    logic        dec_illegal;
    logic        dec_fault;
    logic [1:0]  dec_size;
    logic [1:0]  dec_off;
    logic [3:0]  dec_wstrb;
    logic [31:0] dec_wdata;
`ifdef LSU_MISALIGN_TRAP_EN
    logic        dec_misaligned;
`endif

    // Latched transaction context.
    logic              store_q;
    logic              unsigned_q;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              mem_req_q;
    logic              acked_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [3:0]        mem_wstrb_q;
    logic [31:0]       mem_wdata_q;

    // Registered writeback response.
    logic        resp_we_q;
    logic [4:0]  resp_rd_q;
    logic [31:0] resp_data_q;
    logic        resp_fault_q;

    // Load extraction from the bus word.
    logic [7:0]  lane_byte;
    logic [15:0] lane_half;
    logic [31:0] load_data;

    // Request decode. The low two funct3 bits give the size (B/H/W). Encoding
    // 11 is never a size. For loads, bit 2 only means "unsigned" for B and H,
    // so 110 is also illegal. Stores have no unsigned forms, so any bit-2
    // encoding is illegal. The byte offset used for lane selection is either
    // the raw address offset (alignment trapped) or the offset rounded down
    // to the access size (alignment forced).
    always_comb begin
        dec_size    = req_funct3[1:0];
        dec_illegal = (req_funct3[1:0] == 2'b11) ||
                      (req_funct3[2] && (req_store || req_funct3[1]));
`ifdef LSU_MISALIGN_TRAP_EN
        dec_off        = req_addr[1:0];
        dec_misaligned = ((dec_size == SZ_H) && req_addr[0]) ||
                         ((dec_size == SZ_W) && (req_addr[1:0] != 2'b00));
        dec_fault      = dec_illegal || dec_misaligned;
`else
        dec_fault = dec_illegal;
        case (dec_size)
            SZ_H:    dec_off = {req_addr[1], 1'b0};
            SZ_W:    dec_off = 2'b00;
            default: dec_off = req_addr[1:0];
        endcase
`endif
    end

    // Store strobes and lane replication. Replicating the data across every
    // lane lets the memory pick bytes purely by strobe, with no shifter on
    // the bus side. Loads drive no strobes and no data.
    always_comb begin
        dec_wstrb = 4'b0000;
        dec_wdata = 32'h0000_0000;
        if (req_store) begin
            case (dec_size)
                SZ_B: begin
                    dec_wstrb = 4'b0001 << dec_off;
                    dec_wdata = {4{req_wdata[7:0]}};
                end
                SZ_H: begin
                    dec_wstrb = dec_off[1] ? 4'b1100 : 4'b0011;
                    dec_wdata = {2{req_wdata[15:0]}};
                end
                default: begin
                    dec_wstrb = 4'b1111;
                    dec_wdata = req_wdata;
                end
            endcase
        end
    end

    // Lane selection and extension of the returned word. This uses the
    // latched offset, so the value is only meaningful while the bus acks.
    always_comb begin
        lane_byte = 8'h00;
        load_data = 32'h0000_0000;
        case (off_q)
            2'd0:    lane_byte = mem_rdata[7:0];
            2'd1:    lane_byte = mem_rdata[15:8];
            2'd2:    lane_byte = mem_rdata[23:16];
            default: lane_byte = mem_rdata[31:24];
        endcase
        lane_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (size_q)
            SZ_B:    load_data = unsigned_q ? {24'h000000, lane_byte}
                                            : {{24{lane_byte[7]}}, lane_byte};
            SZ_H:    load_data = unsigned_q ? {16'h0000, lane_half}
                                            : {{16{lane_half[15]}}, lane_half};
            default: load_data = mem_rdata;
        endcase
    end

    // State register. An asynchronous reset abandons any bus transaction in
    // flight. The bus must tolerate the request disappearing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs. BUS moves on only after the
    // registered ack flag is set. This gives the captured load data a full
    // cycle to settle into the response register. It also means an ack that
    // arrives after mem_req has dropped can never re-trigger the transition.
    always_comb begin
        state_next = state;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    state_next = dec_fault ? RESP : BUS;
                end
            end
            BUS: begin
                if (acked_q) begin
                    state_next = RESP;
                end
            end
            RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Transaction datapath. Every request field is captured at accept, so the
    // execute stage may change its outputs right away. Bus fields are only
    // loaded for a legal access. A fault leaves the bus completely untouched.
    // mem_req drops on the ack edge. Read data is captured only when a
    // request is actually outstanding.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            store_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            size_q       <= 2'b00;
            off_q        <= 2'b00;
            mem_req_q    <= 1'b0;
            acked_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wstrb_q  <= 4'b0000;
            mem_wdata_q  <= 32'h0000_0000;
            resp_we_q    <= 1'b0;
            resp_rd_q    <= 5'd0;
            resp_data_q  <= 32'h0000_0000;
            resp_fault_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        store_q      <= req_store;
                        unsigned_q   <= req_funct3[2];
                        size_q       <= dec_size;
                        off_q        <= dec_off;
                        acked_q      <= 1'b0;
                        resp_rd_q    <= req_rd;
                        resp_data_q  <= 32'h0000_0000;
                        resp_fault_q <= dec_fault;
                        resp_we_q    <= !dec_fault && !req_store && (req_rd != 5'd0);
                        mem_req_q    <= !dec_fault;
                        if (!dec_fault) begin
                            mem_addr_q  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_wstrb_q <= dec_wstrb;
                            mem_wdata_q <= dec_wdata;
                        end
                    end
                end
                BUS: begin
                    if (mem_req_q && mem_ack) begin
                        mem_req_q <= 1'b0;
                        acked_q   <= 1'b1;
                        if (!store_q) begin
                            resp_data_q <= load_data;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign mem_req    = mem_req_q;
    assign mem_we     = mem_req_q && store_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wstrb  = mem_wstrb_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_we    = resp_we_q;
    assign resp_rd    = resp_rd_q;
    assign resp_data  = resp_data_q;
    assign resp_fault = resp_fault_q;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu
//
// It runs a table of directed vectors, then a batch of random operations
// checked against a behavioural model. Hand-written sequences cover reset
// and reset while the bus is busy. Expectations track LSU_MISALIGN_TRAP_EN
// the same way the design does.
// ---------------------------------------------------------------------------
module tb_lsu;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic        resp_ready;
    logic        resp_we;
    logic [4:0]  resp_rd;
    logic [31:0] resp_data;
    logic        resp_fault;

    int testCount = 0;
    int failCount = 0;

    // Expected result of one operation, as the specification describes it.
    typedef struct packed {
        logic        fault;
        logic        req;
        logic [31:0] addr;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [31:0] data;
        logic        we;
    } exp_t;

    // What the bench observed on the DUT during one operation.
    typedef struct packed {
        logic        timeout;
        logic        sawReq;
        logic        stable;
        logic [7:0]  reqCyc;
        logic [31:0] addr;
        logic        we;
        logic [3:0]  wstrb;
        logic [31:0] wdata;
        logic [7:0]  lat;
        logic        respWe;
        logic [4:0]  respRd;
        logic [31:0] respData;
        logic        respFault;
    } obs_t;

    // One directed vector: stimulus plus hand-derived expectations.
    typedef struct packed {
        logic        st;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [3:0]  waits;
        logic [31:0] rdata;
        logic [3:0]  bp;
        exp_t        e;
        logic [7:0]  lat;
    } vec_t;

    lsu #(.ADDR_W(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_store  (req_store),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wstrb  (mem_wstrb),
        .mem_wdata  (mem_wdata),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_we    (resp_we),
        .resp_rd    (resp_rd),
        .resp_data  (resp_data),
        .resp_fault (resp_fault)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one value and log any difference.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", name, actual, expected);
        end
    endtask

    // Behavioural model built from the access rules with plain arithmetic.
    // It uses the byte count, the in-word offset, masks and two's complement
    // subtraction for sign extension.
    function automatic exp_t refModel(input logic st, input logic [2:0] f3,
                                      input logic [31:0] addr, input logic [31:0] wdata,
                                      input logic [4:0] rd, input logic [31:0] rdata);
        exp_t   e;
        int     f;
        int     nb;
        int     off;
        logic   legal;
        longint mask;
        longint v;
        e   = '0;
        f   = int'(f3);
        if (st) legal = (f <= 2);
        else    legal = (f == 0 || f == 1 || f == 2 || f == 4 || f == 5);
        nb  = 1 << (f % 4);
        off = int'(addr % 32'd4);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((off % nb) != 0) legal = 1'b0;
`else
        off = off - (off % nb);
`endif
        if (!legal) begin
            e.fault = 1'b1;
            return e;
        end
        e.req  = 1'b1;
        e.addr = addr - (addr % 32'd4);
        mask   = (longint'(1) << (8 * nb)) - 1;
        if (st) begin
            e.wstrb = 4'(((1 << nb) - 1) << off);
            v = longint'(wdata) & mask;
            for (int i = 0; i < 4 / nb; i++) begin
                e.wdata = e.wdata | 32'(v << (8 * nb * i));
            end
        end else begin
            v = (longint'(rdata) >> (8 * off)) & mask;
            if (f < 4 && nb < 4 && v >= (longint'(1) << (8 * nb - 1))) begin
                v = v - (mask + 1);
            end
            e.data = 32'(v);
            e.we   = (rd != 5'd0);
        end
        return e;
    endfunction

    function automatic vec_t mkVec(input logic st, input logic [2:0] f3,
                                   input logic [31:0] addr, input logic [31:0] wdata,
                                   input logic [4:0] rd, input logic [3:0] waits,
                                   input logic [31:0] rdata, input logic [3:0] bp,
                                   input logic fault, input logic [31:0] eAddr,
                                   input logic [3:0] eWstrb, input logic [31:0] eWdata,
                                   input logic [31:0] eData, input logic eWe,
                                   input logic [7:0] lat);
        vec_t v;
        v.st      = st;
        v.f3      = f3;
        v.addr    = addr;
        v.wdata   = wdata;
        v.rd      = rd;
        v.waits   = waits;
        v.rdata   = rdata;
        v.bp      = bp;
        v.e.fault = fault;
        v.e.req   = !fault;
        v.e.addr  = eAddr;
        v.e.wstrb = eWstrb;
        v.e.wdata = eWdata;
        v.e.data  = eData;
        v.e.we    = eWe;
        v.lat     = lat;
        return v;
    endfunction

    // Offer one operation and play the bus with the given number of wait
    // cycles. The task watches the bus fields and returns when resp_valid is
    // seen, or after a bounded number of cycles. The caller must be at a
    // negedge. On return the bench is at the negedge where the response was
    // first seen.
    task automatic applyStimulus(input logic st, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int waits,
                                 input logic [31:0] rdata, output obs_t o);
        int guard;
        int cyc;
        int busCyc;
        o        = '0;
        o.stable = 1'b1;
        guard    = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        req_valid  = 1'b1;
        req_store  = st;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        req_rd     = rd;
        @(posedge clk);
        #1;
        req_valid  = 1'b0;
        req_store  = 1'($urandom_range(0, 1));
        req_funct3 = 3'($urandom_range(0, 7));
        req_addr   = $urandom;
        req_wdata  = $urandom;
        req_rd     = 5'($urandom_range(0, 31));
        cyc    = 1;
        busCyc = 0;
        while (cyc < 40) begin
            @(negedge clk);
            mem_ack   = 1'b0;
            mem_rdata = $urandom;
            if (resp_valid) begin
                o.lat       = 8'(cyc);
                o.respWe    = resp_we;
                o.respRd    = resp_rd;
                o.respData  = resp_data;
                o.respFault = resp_fault;
                break;
            end
            if (mem_req) begin
                if (!o.sawReq) begin
                    o.sawReq = 1'b1;
                    o.reqCyc = 8'(cyc);
                    o.addr   = mem_addr;
                    o.we     = mem_we;
                    o.wstrb  = mem_wstrb;
                    o.wdata  = mem_wdata;
                end else if (mem_addr !== o.addr || mem_we !== o.we ||
                             mem_wstrb !== o.wstrb || mem_wdata !== o.wdata) begin
                    o.stable = 1'b0;
                end
                if (busCyc == waits) begin
                    mem_ack   = 1'b1;
                    mem_rdata = rdata;
                end
                busCyc++;
            end
            @(posedge clk);
            cyc++;
        end
        mem_ack = 1'b0;
        if (o.lat == 8'd0) o.timeout = 1'b1;
    endtask

    // Compare the observations of one operation with its expectation.
    task automatic checkOp(input string tag, input obs_t o, input exp_t e,
                           input logic st, input logic [4:0] rd, input int lat);
        checkOutput({tag, ".timeout"}, 32'(o.timeout), 32'd0);
        checkOutput({tag, ".latency"}, 32'(o.lat), 32'(lat));
        checkOutput({tag, ".fault"}, 32'(o.respFault), 32'(e.fault));
        checkOutput({tag, ".busreq"}, 32'(o.sawReq), 32'(e.req));
        if (e.req) begin
            checkOutput({tag, ".reqcycle"}, 32'(o.reqCyc), 32'd1);
            checkOutput({tag, ".memaddr"}, o.addr, e.addr);
            checkOutput({tag, ".memwe"}, 32'(o.we), 32'(st));
            checkOutput({tag, ".wstrb"}, 32'(o.wstrb), 32'(e.wstrb));
            checkOutput({tag, ".busstable"}, 32'(o.stable), 32'd1);
            if (st) checkOutput({tag, ".wdata"}, o.wdata, e.wdata);
        end
        checkOutput({tag, ".respdata"}, o.respData, e.data);
        checkOutput({tag, ".respwe"}, 32'(o.respWe), 32'(e.we));
        checkOutput({tag, ".resprd"}, 32'(o.respRd), 32'(rd));
    endtask

    // Hold resp_ready low for bp cycles while offering a stray request. The
    // response must stay put and the stray request must be ignored. Then
    // consume the response and confirm the unit is ready again.
    task automatic finishResp(input string tag, input int bp, input exp_t e);
        for (int i = 0; i < bp; i++) begin
            resp_ready = 1'b0;
            req_valid  = 1'b1;
            req_store  = 1'($urandom_range(0, 1));
            req_funct3 = 3'($urandom_range(0, 7));
            req_addr   = $urandom;
            req_rd     = 5'($urandom_range(0, 31));
            @(negedge clk);
            checkOutput({tag, ".bp.valid"}, 32'(resp_valid), 32'd1);
            checkOutput({tag, ".bp.ready"}, 32'(req_ready), 32'd0);
            checkOutput({tag, ".bp.data"}, resp_data, e.data);
            checkOutput({tag, ".bp.fault"}, 32'(resp_fault), 32'(e.fault));
            checkOutput({tag, ".bp.we"}, 32'(resp_we), 32'(e.we));
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        @(negedge clk);
        checkOutput({tag, ".done.ready"}, 32'(req_ready), 32'd1);
        checkOutput({tag, ".done.valid"}, 32'(resp_valid), 32'd0);
    endtask

    vec_t vecs[14];
    obs_t obs;
    exp_t ex;
    logic        rSt;
    logic [2:0]  rF3;
    logic [31:0] rAddr;
    logic [31:0] rWdata;
    logic [4:0]  rRd;
    logic [31:0] rRdata;
    int          rWaits;
    int          rBp;

    initial begin
        // st f3 addr wdata rd waits rdata bp | fault addr wstrb wdata data we lat
        vecs[0]  = mkVec(0, 3'b010, 32'h100, 0, 5, 2, 32'hDEADBEEF, 0,
                         0, 32'h100, 4'b0000, 0, 32'hDEADBEEF, 1, 5);
        vecs[1]  = mkVec(0, 3'b000, 32'h103, 0, 1, 0, 32'h80FF0000, 0,
                         0, 32'h100, 4'b0000, 0, 32'hFFFFFF80, 1, 3);
        vecs[2]  = mkVec(0, 3'b100, 32'h103, 0, 2, 0, 32'h80FF0000, 0,
                         0, 32'h100, 4'b0000, 0, 32'h00000080, 1, 3);
        vecs[3]  = mkVec(0, 3'b001, 32'h102, 0, 3, 0, 32'h80FF0000, 0,
                         0, 32'h100, 4'b0000, 0, 32'hFFFF80FF, 1, 3);
        vecs[4]  = mkVec(1, 3'b000, 32'h201, 32'h12345678, 7, 0, 0, 0,
                         0, 32'h200, 4'b0010, 32'h78787878, 0, 0, 3);
        vecs[5]  = mkVec(1, 3'b001, 32'h202, 32'h12345678, 7, 0, 0, 0,
                         0, 32'h200, 4'b1100, 32'h56785678, 0, 0, 3);
        vecs[6]  = mkVec(1, 3'b010, 32'h300, 32'hCAFEF00D, 0, 1, 0, 0,
                         0, 32'h300, 4'b1111, 32'hCAFEF00D, 0, 0, 4);
`ifdef LSU_MISALIGN_TRAP_EN
        vecs[7]  = mkVec(0, 3'b010, 32'h102, 0, 4, 0, 32'hDEADBEEF, 0,
                         1, 0, 4'b0000, 0, 0, 0, 1);
        vecs[12] = mkVec(0, 3'b001, 32'h101, 0, 11, 0, 32'h00008001, 0,
                         1, 0, 4'b0000, 0, 0, 0, 1);
`else
        vecs[7]  = mkVec(0, 3'b010, 32'h102, 0, 4, 0, 32'hDEADBEEF, 0,
                         0, 32'h100, 4'b0000, 0, 32'hDEADBEEF, 1, 3);
        vecs[12] = mkVec(0, 3'b001, 32'h101, 0, 11, 0, 32'h00008001, 0,
                         0, 32'h100, 4'b0000, 0, 32'hFFFF8001, 1, 3);
`endif
        vecs[8]  = mkVec(0, 3'b010, 32'h104, 0, 0, 0, 32'h11223344, 4,
                         0, 32'h104, 4'b0000, 0, 32'h11223344, 0, 3);
        vecs[9]  = mkVec(0, 3'b011, 32'h100, 0, 9, 0, 0, 1,
                         1, 0, 4'b0000, 0, 0, 0, 1);
        vecs[10] = mkVec(1, 3'b100, 32'h100, 32'hFFFFFFFF, 9, 0, 0, 0,
                         1, 0, 4'b0000, 0, 0, 0, 1);
        vecs[11] = mkVec(0, 3'b101, 32'h100, 0, 10, 0, 32'h12348001, 0,
                         0, 32'h100, 4'b0000, 0, 32'h00008001, 1, 3);
        vecs[13] = mkVec(0, 3'b110, 32'h200, 0, 12, 0, 0, 2,
                         1, 0, 4'b0000, 0, 0, 0, 1);

        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_store  = 1'b0;
        req_funct3 = 3'b000;
        req_addr   = 32'h0;
        req_wdata  = 32'h0;
        req_rd     = 5'd0;
        mem_ack    = 1'b0;
        mem_rdata  = 32'h0;
        resp_ready = 1'b0;

        // Reset state.
        repeat (2) @(negedge clk);
        checkOutput("reset.req_ready", 32'(req_ready), 32'd1);
        checkOutput("reset.mem_req", 32'(mem_req), 32'd0);
        checkOutput("reset.mem_we", 32'(mem_we), 32'd0);
        checkOutput("reset.mem_wstrb", 32'(mem_wstrb), 32'd0);
        checkOutput("reset.resp_valid", 32'(resp_valid), 32'd0);
        checkOutput("reset.resp_data", resp_data, 32'd0);
        checkOutput("reset.resp_fault", 32'(resp_fault), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed table.
        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].st, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
                          vecs[i].rd, int'(vecs[i].waits), vecs[i].rdata, obs);
            checkOp($sformatf("vec%0d", i), obs, vecs[i].e, vecs[i].st, vecs[i].rd,
                    int'(vecs[i].lat));
            finishResp($sformatf("vec%0d", i), int'(vecs[i].bp), vecs[i].e);
        end

        // Random operations against the model.
        for (int n = 0; n < 200; n++) begin
            rSt    = 1'($urandom_range(0, 1));
            rF3    = 3'($urandom_range(0, 7));
            rAddr  = $urandom;
            rWdata = $urandom;
            rRd    = 5'($urandom_range(0, 31));
            rRdata = $urandom;
            rWaits = int'($urandom_range(0, 3));
            rBp    = int'($urandom_range(0, 2));
            ex     = refModel(rSt, rF3, rAddr, rWdata, rRd, rRdata);
            applyStimulus(rSt, rF3, rAddr, rWdata, rRd, rWaits, rRdata, obs);
            checkOp($sformatf("rnd%0d", n), obs, ex, rSt, rRd, ex.fault ? 1 : 3 + rWaits);
            finishResp($sformatf("rnd%0d", n), rBp, ex);
        end

        // Reset while the bus is busy: the request drops without a clock
        // edge, and a later stray ack must not produce a response.
        req_valid  = 1'b1;
        req_store  = 1'b0;
        req_funct3 = 3'b010;
        req_addr   = 32'h400;
        req_rd     = 5'd3;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(negedge clk);
        checkOutput("midreset.before.mem_req", 32'(mem_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset.mem_req", 32'(mem_req), 32'd0);
        checkOutput("midreset.req_ready", 32'(req_ready), 32'd1);
        checkOutput("midreset.resp_valid", 32'(resp_valid), 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        mem_ack   = 1'b1;
        mem_rdata = 32'hA5A5A5A5;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput($sformatf("strayack%0d.resp_valid", i), 32'(resp_valid), 32'd0);
            checkOutput($sformatf("strayack%0d.mem_req", i), 32'(mem_req), 32'd0);
            checkOutput($sformatf("strayack%0d.req_ready", i), 32'(req_ready), 32'd1);
        end
        mem_ack = 1'b0;

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
